// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: line symbol codes, delay-line entry kinds and run length.
// The receive-side checker and decoder import the same package.
package hdb3_pkg;

  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b00;

  localparam int ZERO_RUN_LEN = 4;

  typedef enum logic [1:0] {
    K_ZERO  = 2'd0,
    K_ONE   = 2'd1,
    K_SUB_B = 2'd2,
    K_SUB_V = 2'd3
  } kind_e;

endpackage

// File: rtl/hdb3_encode.sv
// HDB3 transmit encoder: 4-deep kind delay line with 000V/B00V substitution,
// followed by a registered polarity/output stage.
module hdb3_encode
  import hdb3_pkg::*;
#(
  parameter logic [1:0] POS_CODE  = SYM_POS,
  parameter logic [1:0] NEG_CODE  = SYM_NEG,
  parameter logic [1:0] ZERO_CODE = SYM_ZERO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       data_in,
  output logic [1:0] hdb3_out,
  output logic       v_mark
);

  localparam logic [1:0] ZRUN_MAX = 2'(ZERO_RUN_LEN - 1);

  kind_e      dl [4];     // dl[0] newest .. dl[3] oldest
  logic [1:0] zrun;
  logic       par;        // odd count of ONE/SUB_B since last SUB_V
  logic       last_pos;   // polarity of last emitted pulse

  // Input side: shift the line and apply substitution on the 4th zero.
  // The B (if any) replaces the first zero of the run as it moves d2->d3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) dl[i] <= K_ZERO;
      zrun <= 2'd0;
      par  <= 1'b0;
    end else if (valid) begin
      dl[1] <= dl[0];
      dl[2] <= dl[1];
      dl[3] <= dl[2];
      if (data_in) begin
        dl[0] <= K_ONE;
        zrun  <= 2'd0;
        par   <= ~par;
      end else if (zrun != ZRUN_MAX) begin
        dl[0] <= K_ZERO;
        zrun  <= zrun + 2'd1;
      end else begin
        dl[0] <= K_SUB_V;
        zrun  <= 2'd0;
        par   <= 1'b0;
        if (!par) dl[3] <= K_SUB_B;
      end
    end
  end

  // Output side: AMI alternation for ONE/B, V repeats the previous polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdb3_out <= ZERO_CODE;
      v_mark   <= 1'b0;
      last_pos <= 1'b0;
    end else if (valid) begin
      case (dl[3])
        K_ONE, K_SUB_B: begin
          hdb3_out <= last_pos ? NEG_CODE : POS_CODE;
          v_mark   <= 1'b0;
          last_pos <= ~last_pos;
        end
        K_SUB_V: begin
          hdb3_out <= last_pos ? POS_CODE : NEG_CODE;
          v_mark   <= 1'b1;
        end
        default: begin
          hdb3_out <= ZERO_CODE;
          v_mark   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdb3_encode.sv
// Self-checking bench for hdb3_encode: directed HDB3 sequences, valid gaps,
// mid-stream reset and a randomized stream against a whole-sequence reference.
module tb_hdb3_encode;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] Z = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic       data_in = 1'b0;
  logic [1:0] hdb3_out;
  logic       v_mark;

  int n_chk  = 0;
  int n_pass = 0;

  hdb3_encode dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .data_in  (data_in),
    .hdb3_out (hdb3_out),
    .v_mark   (v_mark)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sym_of(input byte c);
    case (c)
      "+":     return P;
      "-":     return N;
      default: return Z;
    endcase
  endfunction

  task automatic step(input logic v, input logic d);
    valid   = v;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b1; data_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0; data_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = i[0]; data_in = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if (hdb3_out !== Z || v_mark !== 1'b0)
        $display("FAIL reset cyc%0d: out=%b v=%b, want out=00 v=0", i, hdb3_out, v_mark);
      else n_pass++;
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_patterns();
    string bits [3] = '{"100001", "00000000", "110000"};
    string exps [3] = '{"0000+000+-", "0000+00+-00-", "0000+-+00+"};
    string vs   [3] = '{"0000000010", "000000010001", "0000000001"};
    for (int c = 0; c < 3; c++) begin
      do_reset();
      for (int i = 0; i < exps[c].len(); i++) begin
        step(1'b1, (i < bits[c].len()) && (bits[c][i] == "1"));
        n_chk++;
        if (hdb3_out !== sym_of(exps[c][i]) || v_mark !== (vs[c][i] == "1"))
          $display("FAIL pattern%0d beat%0d: out=%b v=%b, want out=%b v=%b",
                   c + 1, i, hdb3_out, v_mark, sym_of(exps[c][i]), vs[c][i] == "1");
        else n_pass++;
      end
    end
  endtask

  task automatic test_gaps();
    string bits = "100001";
    string exps = "0000+000+-";
    string vs   = "0000000010";
    do_reset();
    for (int i = 0; i < exps.len(); i++) begin
      step(1'b1, (i < bits.len()) && (bits[i] == "1"));
      for (int g = 0; g <= 3; g++) begin
        if (g > 0) step(1'b0, 1'($urandom));
        n_chk++;
        if (hdb3_out !== sym_of(exps[i]) || v_mark !== (vs[i] == "1"))
          $display("FAIL gaps beat%0d gap%0d: out=%b v=%b, want out=%b v=%b",
                   i, g, hdb3_out, v_mark, sym_of(exps[i]), vs[i] == "1");
        else n_pass++;
      end
    end
  endtask

  // Leaves last pulse +, zero-run 3 and a ONE in flight, then resets over it.
  task automatic test_reset_mid();
    string pre  = "101000";
    string exps = "0000+00+";
    string vs   = "00000001";
    do_reset();
    for (int i = 0; i < pre.len(); i++) step(1'b1, pre[i] == "1");
    rst = 1'b1; valid = 1'b1; data_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++;
    if (hdb3_out !== Z || v_mark !== 1'b0)
      $display("FAIL reset_mid flush: out=%b v=%b, want out=00 v=0", hdb3_out, v_mark);
    else n_pass++;
    for (int i = 0; i < exps.len(); i++) begin
      step(1'b1, 1'b0);
      n_chk++;
      if (hdb3_out !== sym_of(exps[i]) || v_mark !== (vs[i] == "1"))
        $display("FAIL reset_mid beat%0d: out=%b v=%b, want out=%b v=%b",
                 i, hdb3_out, v_mark, sym_of(exps[i]), vs[i] == "1");
      else n_pass++;
    end
  endtask

  task automatic test_random();
    localparam int NB = 3000;
    bit         bits [$];
    int         kind [$];   // 0 zero, 1 one, 2 B, 3 V
    logic [1:0] esym [$];
    bit         ev   [$];
    logic [1:0] rx   [$];
    int zr = 0, pulses = 0, pol = -1, nv = 0, idx;
    int dec [$];
    int last, last_v, dec_err, bad_code, bad_valt, run, max_run;

    for (int i = 0; i < NB; i++) bits.push_back(($urandom_range(3) == 0) ? 1'b1 : 1'b0);

    // Whole-sequence HDB3: each 4th zero of a run becomes V; its run start becomes B
    // when an even number of pulses went out since the previous V.
    for (int i = 0; i < NB; i++) begin
      if (bits[i]) begin
        kind.push_back(1); zr = 0; pulses++;
      end else if (zr < 3) begin
        kind.push_back(0); zr++;
      end else begin
        kind.push_back(3);
        if (pulses % 2 == 0) kind[i - 3] = 2;
        pulses = 0; zr = 0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (kind[i] == 0) begin
        esym.push_back(Z); ev.push_back(1'b0);
      end else if (kind[i] == 3) begin
        esym.push_back(pol > 0 ? P : N); ev.push_back(1'b1);
      end else begin
        pol = -pol;
        esym.push_back(pol > 0 ? P : N); ev.push_back(1'b0);
      end
    end

    do_reset();
    while (nv < NB) begin
      if ($urandom_range(3) != 0) begin
        step(1'b1, bits[nv]);
        nv++;
        if (nv >= 5) rx.push_back(hdb3_out);
      end else begin
        step(1'b0, 1'($urandom));
      end
      idx = nv - 5;
      n_chk++;
      if (idx >= 0 ? (hdb3_out !== esym[idx] || v_mark !== ev[idx])
                   : (hdb3_out !== Z || v_mark !== 1'b0))
        $display("FAIL random beat%0d: out=%b v=%b, want out=%b v=%b", nv, hdb3_out, v_mark,
                 idx >= 0 ? esym[idx] : Z, idx >= 0 ? ev[idx] : 1'b0);
      else n_pass++;
    end

    // Receive-side view: a pulse repeating the previous polarity is a V and
    // zeroes itself plus the three preceding positions.
    last = -1; last_v = 0; bad_code = 0; bad_valt = 0; run = 0; max_run = 0;
    for (int k = 0; k < rx.size(); k++) begin
      if (rx[k] == Z) begin
        dec.push_back(0); run++;
        if (run > max_run) max_run = run;
      end else if (rx[k] == P || rx[k] == N) begin
        int p = (rx[k] == P) ? 1 : -1;
        run = 0;
        if (p == last) begin
          if (last_v == p) bad_valt++;
          last_v = p;
          dec.push_back(0);
          for (int j = 1; j <= 3; j++) if (k - j >= 0) dec[k - j] = 0;
        end else begin
          dec.push_back(1);
        end
        last = p;
      end else begin
        bad_code++; dec.push_back(0);
      end
    end
    dec_err = 0;
    for (int k = 0; k < dec.size(); k++) if (dec[k] != int'(bits[k])) dec_err++;

    n_chk++;
    if (dec_err != 0) $display("FAIL random decode: %0d bit errors, want 0", dec_err);
    else n_pass++;
    n_chk++;
    if (bad_code != 0) $display("FAIL random code11: %0d illegal symbols, want 0", bad_code);
    else n_pass++;
    n_chk++;
    if (max_run > 3) $display("FAIL random zero_run: longest %0d, want <=3", max_run);
    else n_pass++;
    n_chk++;
    if (bad_valt != 0) $display("FAIL random v_alternate: %0d repeats, want 0", bad_valt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
